// File: rtl/modexp_pkg.sv
// Shared types for the modular-exponentiation controller: FSM states, operand-mux
// op codes, default operand width and small state-decoding helpers.
package modexp_pkg;

  localparam int SIZE_DEFAULT = 64;

  typedef enum logic [3:0] {
    IDLE,
    RED_REQ,
    RED_WAIT,
    SCAN,
    SQR_REQ,
    SQR_WAIT,
    MUL_REQ,
    MUL_WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_RED,
    OP_SQR,
    OP_MUL
  } op_t;

  function automatic logic is_req(input state_t s);
    return (s == RED_REQ) || (s == SQR_REQ) || (s == MUL_REQ);
  endfunction

  function automatic op_t op_for(input state_t s);
    case (s)
      SQR_REQ: return OP_SQR;
      MUL_REQ: return OP_MUL;
      default: return OP_RED;
    endcase
  endfunction

endpackage

// File: rtl/modexp_opmux.sv
// Registered operand mux: on load, selects the multiplier a/b operands for the
// requested op (reduce: base*1, square: R*R, multiply: R*B) and holds them.
module modexp_opmux
  import modexp_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [1:0]      op,
  input  logic [SIZE-1:0] r_val,
  input  logic [SIZE-1:0] b_val,
  input  logic [SIZE-1:0] base_val,
  output logic [SIZE-1:0] mm_a,
  output logic [SIZE-1:0] mm_b
);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mm_a <= '0;
      mm_b <= '0;
    end else if (load) begin
      case (op)
        OP_SQR: begin
          mm_a <= r_val;
          mm_b <= r_val;
        end
        OP_MUL: begin
          mm_a <= r_val;
          mm_b <= b_val;
        end
        default: begin
          mm_a <= base_val;
          mm_b <= SIZE'(1);
        end
      endcase
    end
  end

endmodule

// File: rtl/mod_exp_controller.sv
// Left-to-right square-and-multiply sequencer driving one shared a*b mod n unit.
// Define MODEXP_LEADING_ZERO_SKIP_EN to skip leading exponent zeros via a SCAN state.
module mod_exp_controller
  import modexp_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] s_base_tdata,
  input  logic [SIZE-1:0] s_exp_tdata,
  input  logic [SIZE-1:0] s_mod_tdata,
  input  logic            s_tvalid,
  output logic            s_tready,
  output logic [SIZE-1:0] mm_a_tdata,
  output logic [SIZE-1:0] mm_b_tdata,
  output logic [SIZE-1:0] mm_n_tdata,
  output logic            mm_req_tvalid,
  input  logic            mm_req_tready,
  input  logic [SIZE-1:0] mm_res_tdata,
  input  logic            mm_res_tvalid,
  output logic            mm_res_tready,
  output logic [SIZE-1:0] m_tdata,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic            busy,
  output logic            err
);

  localparam int CW = $clog2(SIZE);

  state_t          state_q, state_d;
  logic [SIZE-1:0] exp_q, exp_d;
  logic [SIZE-1:0] n_q, n_d;
  logic [SIZE-1:0] b_q, b_d;
  logic [SIZE-1:0] r_q, r_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            err_q, err_d;
  logic            advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      n_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      n_q     <= n_d;
      b_q     <= b_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    n_d     = n_q;
    b_d     = b_q;
    r_d     = r_q;
    idx_d   = idx_q;
    err_d   = err_q;
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_tvalid) begin
          exp_d = s_exp_tdata;
          n_d   = s_mod_tdata;
          idx_d = CW'(SIZE - 1);
          r_d   = SIZE'(1);
          err_d = 1'b0;
          if (s_mod_tdata == '0) begin
            err_d   = 1'b1;
            r_d     = '0;
            state_d = DONE;
          end else if (s_mod_tdata == SIZE'(1)) begin
            r_d     = '0;
            state_d = DONE;
          end else begin
            state_d = RED_REQ;
          end
        end
      end
      RED_REQ: if (mm_req_tready) state_d = RED_WAIT;
      RED_WAIT: begin
        if (mm_res_tvalid) begin
          b_d = mm_res_tdata;
          if (exp_q == '0) begin
            r_d     = SIZE'(1);
            state_d = DONE;
          end else begin
`ifdef MODEXP_LEADING_ZERO_SKIP_EN
            state_d = SCAN;
`else
            state_d = SQR_REQ;
`endif
          end
        end
      end
`ifdef MODEXP_LEADING_ZERO_SKIP_EN
      // exp is non-zero here, so the scan always stops on a set bit.
      SCAN: begin
        if (exp_q[idx_q]) begin
          r_d     = b_q;
          advance = 1'b1;
        end else begin
          idx_d = idx_q - CW'(1);
        end
      end
`endif
      SQR_REQ: if (mm_req_tready) state_d = SQR_WAIT;
      SQR_WAIT: begin
        if (mm_res_tvalid) begin
          r_d = mm_res_tdata;
          if (exp_q[idx_q]) state_d = MUL_REQ;
          else              advance = 1'b1;
        end
      end
      MUL_REQ: if (mm_req_tready) state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mm_res_tvalid) begin
          r_d     = mm_res_tdata;
          advance = 1'b1;
        end
      end
      DONE: if (m_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Move to the next lower exponent bit, or finish after bit 0.
    if (advance) begin
      if (idx_q == '0) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q - CW'(1);
        state_d = SQR_REQ;
      end
    end
  end

  // Operands are captured on entry to a request state, using next-cycle R so a
  // result landing on the same edge is already reflected.
  modexp_opmux #(.SIZE(SIZE)) u_opmux (
    .clk      (clk),
    .rst      (rst),
    .load     (is_req(state_d) && !is_req(state_q)),
    .op       (op_for(state_d)),
    .r_val    (r_d),
    .b_val    (b_d),
    .base_val (s_base_tdata),
    .mm_a     (mm_a_tdata),
    .mm_b     (mm_b_tdata)
  );

  assign mm_n_tdata    = n_q;
  assign s_tready      = (state_q == IDLE);
  assign mm_req_tvalid = is_req(state_q);
  assign mm_res_tready = (state_q == IDLE) || (state_q == RED_WAIT) ||
                         (state_q == SQR_WAIT) || (state_q == MUL_WAIT);
  assign m_tvalid      = (state_q == DONE);
  assign m_tdata       = (state_q == DONE) ? r_q : '0;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_mod_exp_controller.sv
// Bench for mod_exp_controller: an 8-bit and a 64-bit instance, each served by a
// behavioural a*b mod n unit with random stalls, checked against a plain-arithmetic model.
module tb_mod_exp_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_base, s_exp, s_mod;
  logic        s_tvalid, m_tready, stall_req;
  logic [1:0]  inject;
  int          sel;

  logic [1:0]  s_tv, s_tr, m_tv, busy_w, err_w, req_v, req_r, res_v, res_r;
  logic [63:0] m_data[2], mm_a[2], mm_b[2], mm_n[2], mm_res[2];
  int          ops[2];
  logic [7:0]  a8, b8, n8, md8;

  int n_tests = 0;
  int n_fail  = 0;
  int ops0;

  always #5 clk = ~clk;

  assign s_tv      = {s_tvalid && (sel == 1), s_tvalid && (sel == 0)};
  assign mm_a[0]   = {56'b0, a8};
  assign mm_b[0]   = {56'b0, b8};
  assign mm_n[0]   = {56'b0, n8};
  assign m_data[0] = {56'b0, md8};

  mod_exp_controller #(.SIZE(8)) dut8 (
    .clk(clk), .rst(rst),
    .s_base_tdata(s_base[7:0]), .s_exp_tdata(s_exp[7:0]), .s_mod_tdata(s_mod[7:0]),
    .s_tvalid(s_tv[0]), .s_tready(s_tr[0]),
    .mm_a_tdata(a8), .mm_b_tdata(b8), .mm_n_tdata(n8),
    .mm_req_tvalid(req_v[0]), .mm_req_tready(req_r[0]),
    .mm_res_tdata(mm_res[0][7:0]), .mm_res_tvalid(res_v[0]), .mm_res_tready(res_r[0]),
    .m_tdata(md8), .m_tvalid(m_tv[0]), .m_tready(m_tready),
    .busy(busy_w[0]), .err(err_w[0])
  );

  mod_exp_controller #(.SIZE(64)) dut64 (
    .clk(clk), .rst(rst),
    .s_base_tdata(s_base), .s_exp_tdata(s_exp), .s_mod_tdata(s_mod),
    .s_tvalid(s_tv[1]), .s_tready(s_tr[1]),
    .mm_a_tdata(mm_a[1]), .mm_b_tdata(mm_b[1]), .mm_n_tdata(mm_n[1]),
    .mm_req_tvalid(req_v[1]), .mm_req_tready(req_r[1]),
    .mm_res_tdata(mm_res[1]), .mm_res_tvalid(res_v[1]), .mm_res_tready(res_r[1]),
    .m_tdata(m_data[1]), .m_tvalid(m_tv[1]), .m_tready(m_tready),
    .busy(busy_w[1]), .err(err_w[1])
  );

  function automatic logic [63:0] mul_mod(input logic [63:0] a, b, n);
    logic [127:0] p;
    p = {64'b0, a} * {64'b0, b};
    return 64'(p % {64'b0, n});
  endfunction

  // Reference: right-to-left binary exponentiation on wide integers.
  function automatic logic [63:0] ref_modexp(input logic [63:0] b, e, n);
    logic [127:0] r, sq, nn;
    if (n == 0) return 64'd0;
    nn = {64'b0, n};
    r  = 128'd1 % nn;
    sq = {64'b0, b} % nn;
    for (int k = 0; k < 64; k++) begin
      if (e[k]) r = (r * sq) % nn;
      sq = (sq * sq) % nn;
    end
    return r[63:0];
  endfunction

  function automatic int exp_ops(input int size, input logic [63:0] e, n);
    int pc, k;
    if (n <= 1) return 0;
    if (e == 0) return 1;
    pc = $countones(e);
    k  = 0;
    for (int j = 0; j < 64; j++) if (e[j]) k = j;
`ifdef MODEXP_LEADING_ZERO_SKIP_EN
    return 1 + k + pc - 1;
`else
    return 1 + size + pc + 0 * k;
`endif
  endfunction

  // Behavioural multiplier per instance: one request at a time, 0-5 cycle stalls.
  for (genvar g = 0; g < 2; g++) begin : g_mm
    logic        rdy, pend, rv;
    logic [3:0]  req_cnt, res_cnt;
    logic [63:0] res_d;
    int          cnt = 0;

    assign req_r[g]  = rdy;
    assign res_v[g]  = rv;
    assign mm_res[g] = res_d;
    assign ops[g]    = cnt;

    always @(posedge clk) begin
      if (rst) begin
        rdy     <= 1'b0;
        pend    <= 1'b0;
        rv      <= 1'b0;
        req_cnt <= '0;
        res_cnt <= '0;
        res_d   <= '0;
      end else begin
        if (req_v[g] && rdy) begin
          pend    <= 1'b1;
          rdy     <= 1'b0;
          cnt     <= cnt + 1;
          res_d   <= mul_mod(mm_a[g], mm_b[g], mm_n[g]);
          res_cnt <= 4'($urandom_range(0, 5));
          req_cnt <= 4'($urandom_range(0, 5));
        end else begin
          rdy <= !pend && !rv && (req_cnt == 0) && !stall_req;
          if (req_cnt != 0) req_cnt <= req_cnt - 4'd1;
        end
        if (pend && !rv) begin
          if (res_cnt == 0) rv <= 1'b1;
          else              res_cnt <= res_cnt - 4'd1;
        end
        if (inject[g]) begin
          rv    <= 1'b1;
          res_d <= 64'h5A;
        end
        if (rv && res_r[g]) begin
          rv   <= 1'b0;
          pend <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic start_job(input int g, input logic [63:0] b, e, n);
    int t;
    sel = g;
    @(negedge clk);
    s_base   = b;
    s_exp    = e;
    s_mod    = n;
    s_tvalid = 1'b1;
    ops0     = ops[g];
    t = 0;
    while (!s_tr[g] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("accept_timeout", s_tr[g], 1);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int g, output bit ok);
    int t;
    t = 0;
    while (!m_tv[g] && t < 5000) begin
      @(negedge clk);
      t++;
    end
    ok = m_tv[g];
    if (!ok) check("done_timeout", m_tv[g], 1);
  endtask

  task automatic run_job(input int g, input logic [63:0] b, e, n, input string tag);
    logic [63:0] mask;
    bit ok;
    int sz;
    mask = (g == 0) ? 64'hFF : '1;
    sz   = (g == 0) ? 8 : 64;
    start_job(g, b & mask, e & mask, n & mask);
    wait_done(g, ok);
    if (ok) begin
      check({tag, "_data"}, m_data[g], ref_modexp(b & mask, e & mask, n & mask));
      check({tag, "_err"}, err_w[g], ((n & mask) == 0) ? 64'd1 : 64'd0);
      check({tag, "_ops"}, 64'(ops[g] - ops0), 64'(exp_ops(sz, e & mask, n & mask)));
    end
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int bad, t, ops_s;
    logic [63:0] a0, b0, n0, rb, re, rn;

    rst = 1'b1; s_base = '0; s_exp = '0; s_mod = '0; s_tvalid = 1'b0;
    m_tready = 1'b1; stall_req = 1'b0; inject = '0; sel = 0;
    repeat (3) @(negedge clk);
    check("rst_s_tready", s_tr[0], 1);
    check("rst_busy", busy_w[0], 0);
    check("rst_m_tvalid", m_tv[0], 0);
    check("rst_m_tdata", m_data[0], 0);
    check("rst_err", err_w[0], 0);
    check("rst_req_valid", req_v[0], 0);
    check("rst64_s_tready", s_tr[1], 1);
    rst = 1'b0;

    run_job(0, 3, 5, 7, "b3e5n7");
    run_job(1, 2, 10, 1000, "w64_2_10");
    run_job(1, 1234, 1, 1000, "w64_reduce");
    run_job(0, 5, 0, 13, "exp0");
    run_job(0, 9, 7, 1, "n1");
    run_job(0, 9, 7, 0, "n0");
    repeat (3) @(negedge clk);
    check("err_sticky", err_w[0], 1);
    run_job(0, 4, 3, 10, "err_clear_on_accept");
    run_job(0, 6, 2, 0, "n0_again");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("err_clear_on_rst", err_w[0], 0);

    // Output held while downstream stalls; no new job accepted meanwhile.
    m_tready = 1'b0;
    start_job(0, 3, 5, 7);
    wait_done(0, ok);
    if (ok) begin
      check("hold_data", m_data[0], 5);
      bad = 0;
      s_base = 2; s_exp = 3; s_mod = 11; s_tvalid = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (m_tv[0] !== 1'b1 || m_data[0] !== 64'd5 || s_tr[0] !== 1'b0) bad++;
      end
      check("hold_stable_cycles", 64'(bad), 0);
      m_tready = 1'b1;
      @(negedge clk);
      check("hold_release_ready", s_tr[0], 1);
      check("hold_release_mvalid", m_tv[0], 0);
      ops0 = ops[0];
      @(negedge clk);
      s_tvalid = 1'b0;
      check("hold_next_accept", busy_w[0], 1);
      wait_done(0, ok);
      if (ok) check("hold_next_data", m_data[0], 8);
      @(negedge clk);
    end
    m_tready = 1'b1;
    s_tvalid = 1'b0;

    // Multiplier refuses requests: operands must stay put, only one request.
    stall_req = 1'b1;
    start_job(0, 3, 5, 7);
    t = 0;
    while (!req_v[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("stall_req_seen", req_v[0], 1);
    a0 = mm_a[0]; b0 = mm_b[0]; n0 = mm_n[0]; ops_s = ops[0];
    check("stall_a", a0, 3);
    check("stall_b", b0, 1);
    check("stall_n", n0, 7);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (mm_a[0] !== a0 || mm_b[0] !== b0 || mm_n[0] !== n0 || req_v[0] !== 1'b1) bad++;
    end
    check("stall_stable", 64'(bad), 0);
    check("stall_no_extra_req", 64'(ops[0] - ops_s), 0);
    stall_req = 1'b0;
    wait_done(0, ok);
    if (ok) begin
      check("stall_data", m_data[0], 5);
      check("stall_ops", 64'(ops[0] - ops0), 64'(exp_ops(8, 5, 7)));
    end
    @(negedge clk);

    // A stray result while idle is consumed and produces no output.
    @(negedge clk);
    ops_s  = ops[0];
    inject = 2'b01;
    @(negedge clk);
    inject = 2'b00;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_tv[0] !== 1'b0 || busy_w[0] !== 1'b0) bad++;
    end
    check("drain_no_output", 64'(bad), 0);
    check("drain_consumed", res_v[0], 0);
    check("drain_no_req", 64'(ops[0] - ops_s), 0);
    run_job(0, 3, 5, 7, "after_drain");

    // Reset while waiting on the first square result.
    start_job(0, 3, 5, 7);
    t = 0;
    while (!((ops[0] - ops0) == 2 && res_r[0]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rstjob_in_sqr_wait", res_r[0], 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstjob_busy", busy_w[0], 0);
    check("rstjob_s_tready", s_tr[0], 1);
    check("rstjob_req_valid", req_v[0], 0);
    check("rstjob_m_tvalid", m_tv[0], 0);
    check("rstjob_m_tdata", m_data[0], 0);
    check("rstjob_err", err_w[0], 0);
    rst = 1'b0;
    run_job(0, 3, 5, 7, "after_rst");

    for (int j = 0; j < 24; j++) begin
      rb = 64'($urandom_range(0, 255));
      re = (j % 6 == 0) ? 64'd0 : 64'($urandom_range(0, 255));
      rn = (j % 8 == 0) ? 64'($urandom_range(0, 1)) : 64'($urandom_range(2, 255));
      run_job(0, rb, re, rn, "rand8");
    end
    for (int j = 0; j < 4; j++) begin
      rb = {$urandom, $urandom};
      re = {$urandom, $urandom};
      rn = {$urandom, $urandom} | 64'h2;
      run_job(1, rb, re, rn, "rand64");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
